issue_ctrl: RTL and testbench
=============================

Name: issue_ctrl

Overview:
- Issue controller between IDU and the ID/EX pipeline register.
- Decides each cycle whether the decoded instruction may enter EX:
  - tracks in-flight destination registers in a scoreboard and holds issue on RAW hazards;
  - serialises CSR/system instructions;
  - discards the wrong-path decode slot on a branch redirect.
- Drives the valid input and consumes the ready output of the ID/EX handshake; the core has no forwarding network, so the scoreboard is the only hazard mechanism.

Parameters:
- NREG, 32, architectural register count; x0 is never tracked.
- CNT_W, 2, width of each per-register pending counter; max 2^CNT_W-1 outstanding writes per register.
- INFL_W, 3, width of the total in-flight instruction counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- d_valid_i  in  1  IDU has a decoded instruction
- d_ready_o  out  1  IDU may advance (instruction consumed or discarded)
- d_rs1_i  in  5  source register 1
- d_rs2_i  in  5  source register 2
- d_use_rs1_i  in  1  instruction reads rs1
- d_use_rs2_i  in  1  instruction reads rs2
- d_rd_i  in  5  destination register
- d_wenReg_i  in  1  instruction writes rd
- d_is_sys_i  in  1  CSR/ecall/mret/fence: must issue alone
- E_valid_o  out  1  to ID/EX pin_valid
- E_ready_i  in  1  from ID/EX pin_ready
- redirect_i  in  1  EXU branch/jump mispredict this cycle
- w_retire_i  in  1  an instruction leaves WB this cycle
- w_wenReg_i  in  1  retiring instruction wrote a register
- w_rd_i  in  5  retiring instruction's rd
- w_is_sys_i  in  1  retiring instruction is a system instruction
- stall_o  out  1  valid decode held this cycle (perf counter and debug)

Behaviour:
- State registers: FSM state, pending counter per register 1..NREG-1, infl (total in-flight count).
- Reset (rst_i=1 at a clock edge): state=RUN, all counters 0, infl=0. While rst_i=1, E_valid_o=0, d_ready_o=0, stall_o=0.
- All outputs are combinational from state and inputs; issue adds zero latency.
- hazard = (d_use_rs1_i & rs1≠0 & pend[rs1]≠0) | (d_use_rs2_i & rs2≠0 & pend[rs2]≠0) | (d_wenReg_i & rd≠0 & pend[rd]==max).
- FSM states:
  - RUN: normal issue.
  - DRAIN: a system instruction waits for infl==0.
  - SERIAL: a system instruction is in flight; nothing issues.
- FSM transitions:
  - RUN, decode is valid sys, infl≠0 → DRAIN (not issued).
  - RUN or DRAIN, decode is valid sys, infl==0, no hazard, E_ready_i → issue it, go to SERIAL.
  - SERIAL, w_retire_i & w_is_sys_i → RUN.
- can_issue = d_valid_i & ~hazard & ~redirect_i & (state==RUN ? ~(d_is_sys_i & infl≠0) : state==DRAIN & infl==0).
- E_valid_o = can_issue. Issue fires when E_valid_o & E_ready_i.
- d_ready_o = (E_valid_o & E_ready_i) | (redirect_i & d_valid_i).
- redirect_i overrides everything:
  - the decode slot is discarded (d_ready_o=1, E_valid_o=0, no scoreboard update);
  - DRAIN → RUN, since the sys instruction was wrong-path;
  - SERIAL is unaffected.
- stall_o = d_valid_i & ~d_ready_o.
- Scoreboard:
  - issue with wen & rd≠0: pend[rd]+1;
  - retire with w_wenReg_i & w_rd_i≠0: pend[w_rd_i]-1;
  - both on the same register in one cycle: unchanged.
- infl: +1 on issue, -1 on w_retire_i; simultaneous events leave it unchanged.
- Counters saturate-check in simulation: assert no increment at max and no decrement at 0.
- Because there is no forwarding, a retiring register is not released until the next cycle; reading the same-cycle WB register still stalls one cycle.
- Wrong-path instructions never issue, because the branch resolves in EX; no scoreboard rollback exists.

Decomposition:
- Shared package additions:
  - issue_state_e enum {RUN, DRAIN, SERIAL};
  - constants ysyx_23060251_nreg and ysyx_23060251_infl_w.
  - The existing rs_bus macro is reused for the 5-bit fields.
- One natural sub-module, issue_scoreboard: pending-counter array, hazard compare, infl counter.
- The top level holds the FSM and handshake gating.

Test Plan:
- Reset then idle: rst_i=1 for 2 cycles with d_valid_i=1 → E_valid_o=0 and d_ready_o=0. After reset, infl=0 and all pend counters are 0.
- RAW stall: issue addi x5 (wen, rd=5); next decode reads rs1=5 → stall_o=1 until the cycle after w_retire_i with w_rd_i=5, then issues.
- x0 and use-flags: a producer of rd=0 followed by a consumer of rs1=0 → no stall. A consumer with rs2=5 pending but d_use_rs2_i=0 → no stall.
- Simultaneous issue and retire on x7: pend[7]=1, retire x7 and issue a writer of x7 in the same cycle → pend[7] stays 1, and a reader of x7 the next cycle stalls.
- CSR serialisation: infl=2, csrrw arrives → DRAIN. After 2 retires it issues, state=SERIAL. Younger add stalls until w_is_sys_i retire, then RUN.
- Redirect: d_valid_i=1 with hazard, redirect_i=1 → d_ready_o=1, E_valid_o=0, pend unchanged. Repeat from DRAIN → state returns to RUN.

Source files
------------

// File: rtl/issue_ctrl_pkg.sv
// issue_ctrl_pkg: shared types and sizing constants for the issue controller
package issue_ctrl_pkg;
  localparam int ysyx_23060251_nreg   = 32;
  localparam int ysyx_23060251_infl_w = 3;
  typedef enum logic [1:0] {RUN, DRAIN, SERIAL} issue_state_e;
endpackage

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: per-register pending-write counters, RAW/WAW hazard check, in-flight count
module issue_scoreboard
  import issue_ctrl_pkg::*;
#(
  parameter int NREG   = ysyx_23060251_nreg,
  parameter int CNT_W  = 2,
  parameter int INFL_W = ysyx_23060251_infl_w
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [4:0] rs1_i,
  input  logic [4:0] rs2_i,
  input  logic       use_rs1_i,
  input  logic       use_rs2_i,
  input  logic [4:0] rd_i,
  input  logic       wen_i,
  input  logic       issue_i,
  input  logic       retire_i,
  input  logic       w_wen_i,
  input  logic [4:0] w_rd_i,
  output logic       hazard_o,
  output logic       infl_zero_o
);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [INFL_W-1:0] INFL_MAX = '1;
  logic [CNT_W-1:0]  pend_q [NREG];
  logic [CNT_W-1:0]  pend_d [NREG];
  logic [NREG-1:0]   inc, dec;
  logic [INFL_W-1:0] infl_q, infl_d;
  // x0 is never tracked: inc/dec stay 0 for index 0, so its counter never leaves 0
  always_comb begin
    inc = '0;
    dec = '0;
    for (int i = 1; i < NREG; i++) begin
      inc[i] = issue_i & wen_i & (rd_i == 5'(i));
      dec[i] = retire_i & w_wen_i & (w_rd_i == 5'(i));
    end
    for (int i = 0; i < NREG; i++) pend_d[i] = pend_q[i] + CNT_W'(inc[i]) - CNT_W'(dec[i]);
    infl_d = infl_q + INFL_W'(issue_i) - INFL_W'(retire_i);
  end
  assign hazard_o = (use_rs1_i & |rs1_i & |pend_q[rs1_i])
                  | (use_rs2_i & |rs2_i & |pend_q[rs2_i])
                  | (wen_i & |rd_i & (pend_q[rd_i] == CNT_MAX));
  assign infl_zero_o = infl_q == '0;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++) pend_q[i] <= '0;
      infl_q <= '0;
    end else begin
      pend_q <= pend_d;
      infl_q <= infl_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 1; i < NREG; i++) begin
        assert (!(inc[i] && !dec[i] && pend_q[i] == CNT_MAX));
        assert (!(dec[i] && !inc[i] && pend_q[i] == '0));
      end
      assert (!(issue_i && !retire_i && infl_q == INFL_MAX));
      assert (!(retire_i && !issue_i && infl_q == '0));
    end
  end
endmodule

// File: rtl/issue_ctrl.sv
// issue_ctrl: gates IDU -> ID/EX issue on scoreboard hazards, serialises system
// instructions and discards the decode slot on a branch redirect.
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int NREG   = ysyx_23060251_nreg,
  parameter int CNT_W  = 2,
  parameter int INFL_W = ysyx_23060251_infl_w
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       d_valid_i,
  output logic       d_ready_o,
  input  logic [4:0] d_rs1_i,
  input  logic [4:0] d_rs2_i,
  input  logic       d_use_rs1_i,
  input  logic       d_use_rs2_i,
  input  logic [4:0] d_rd_i,
  input  logic       d_wenReg_i,
  input  logic       d_is_sys_i,
  output logic       E_valid_o,
  input  logic       E_ready_i,
  input  logic       redirect_i,
  input  logic       w_retire_i,
  input  logic       w_wenReg_i,
  input  logic [4:0] w_rd_i,
  input  logic       w_is_sys_i,
  output logic       stall_o
);
  issue_state_e state_q, state_d;
  logic hazard, infl_zero, can_issue, fire;
  issue_scoreboard #(.NREG(NREG), .CNT_W(CNT_W), .INFL_W(INFL_W)) u_sb (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rs1_i       (d_rs1_i),
    .rs2_i       (d_rs2_i),
    .use_rs1_i   (d_use_rs1_i),
    .use_rs2_i   (d_use_rs2_i),
    .rd_i        (d_rd_i),
    .wen_i       (d_wenReg_i),
    .issue_i     (fire),
    .retire_i    (w_retire_i),
    .w_wen_i     (w_wenReg_i),
    .w_rd_i      (w_rd_i),
    .hazard_o    (hazard),
    .infl_zero_o (infl_zero)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= RUN;
    else state_q <= state_d;
  end
  // a redirect means any sys instruction waiting in DRAIN was wrong-path
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (d_valid_i & d_is_sys_i & ~redirect_i) state_d = !infl_zero ? DRAIN : fire ? SERIAL : RUN;
      DRAIN:   state_d = redirect_i ? RUN : fire ? SERIAL : DRAIN;
      SERIAL:  state_d = (w_retire_i & w_is_sys_i) ? RUN : SERIAL;
      default: state_d = RUN;
    endcase
  end
  always_comb begin
    can_issue = d_valid_i & ~hazard & ~redirect_i &
                (state_q == RUN ? ~(d_is_sys_i & ~infl_zero) : (state_q == DRAIN) & infl_zero);
    E_valid_o = ~rst_i & can_issue;
    fire      = E_valid_o & E_ready_i;
    d_ready_o = ~rst_i & (fire | (redirect_i & d_valid_i));
    stall_o   = ~rst_i & d_valid_i & ~d_ready_o;
  end
endmodule

// File: tb/tb_issue_ctrl.sv
// tb_issue_ctrl: directed bench with an issue-order scoreboard for issue_ctrl
module tb_issue_ctrl;
  import issue_ctrl_pkg::*;
  logic clk = 0, rst_i;
  logic d_valid_i, d_ready_o, d_use_rs1_i, d_use_rs2_i, d_wenReg_i, d_is_sys_i;
  logic [4:0] d_rs1_i, d_rs2_i, d_rd_i, w_rd_i;
  logic E_valid_o, E_ready_i, redirect_i, w_retire_i, w_wenReg_i, w_is_sys_i, stall_o;
  int checks = 0, errors = 0;
  logic [4:0] exp_q[$];

  issue_ctrl dut (
    .clk_i(clk), .rst_i(rst_i), .d_valid_i(d_valid_i), .d_ready_o(d_ready_o),
    .d_rs1_i(d_rs1_i), .d_rs2_i(d_rs2_i), .d_use_rs1_i(d_use_rs1_i), .d_use_rs2_i(d_use_rs2_i),
    .d_rd_i(d_rd_i), .d_wenReg_i(d_wenReg_i), .d_is_sys_i(d_is_sys_i),
    .E_valid_o(E_valid_o), .E_ready_i(E_ready_i), .redirect_i(redirect_i),
    .w_retire_i(w_retire_i), .w_wenReg_i(w_wenReg_i), .w_rd_i(w_rd_i), .w_is_sys_i(w_is_sys_i),
    .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pend(input int i);
    return 32'(dut.u_sb.pend_q[i]);
  endfunction

  task automatic dec(input logic [4:0] rs1, input bit u1, input logic [4:0] rs2, input bit u2,
                     input logic [4:0] rd, input bit wen, input bit sys);
    d_valid_i = 1; d_rs1_i = rs1; d_use_rs1_i = u1; d_rs2_i = rs2; d_use_rs2_i = u2;
    d_rd_i = rd; d_wenReg_i = wen; d_is_sys_i = sys;
  endtask

  task automatic nodec();
    dec(0, 0, 0, 0, 0, 0, 0);
    d_valid_i = 0;
  endtask

  task automatic ret(input bit wen, input logic [4:0] rd, input bit sys);
    w_retire_i = 1; w_wenReg_i = wen; w_rd_i = rd; w_is_sys_i = sys;
  endtask

  // sample combinational outputs mid-cycle, match any issue against the scoreboard, then advance
  task automatic step(input string tag, input bit ev, input bit dr, input bit st);
    #3;
    chk({tag, ".E_valid"}, 32'(E_valid_o), 32'(ev));
    chk({tag, ".d_ready"}, 32'(d_ready_o), 32'(dr));
    chk({tag, ".stall"}, 32'(stall_o), 32'(st));
    if (E_valid_o && E_ready_i) begin
      chk({tag, ".q_nonempty"}, 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk({tag, ".issued_rd"}, 32'(d_rd_i), 32'(exp_q.pop_front()));
    end
    @(posedge clk);
    #1;
    w_retire_i = 0; w_wenReg_i = 0; w_rd_i = 0; w_is_sys_i = 0; redirect_i = 0;
  endtask

  initial begin
    int nz;
    rst_i = 1; E_ready_i = 1; redirect_i = 0;
    w_retire_i = 0; w_wenReg_i = 0; w_rd_i = 0; w_is_sys_i = 0;
    dec(0, 0, 0, 0, 3, 1, 0);
    @(posedge clk);
    #1;
    step("rst0", 0, 0, 0);
    step("rst1", 0, 0, 0);
    rst_i = 0;
    nodec();
    chk("rst_state", 32'(dut.state_q), 32'(RUN));
    chk("rst_infl", 32'(dut.u_sb.infl_q), 0);
    nz = 0;
    for (int i = 0; i < 32; i++) if (pend(i) != 0) nz++;
    chk("rst_pend_nonzero", 32'(nz), 0);
    // RAW hazard on x5, released the cycle after its retire
    dec(0, 0, 0, 0, 5, 1, 0); exp_q.push_back(5); step("addi5", 1, 1, 0);
    dec(5, 1, 0, 0, 6, 1, 0); exp_q.push_back(6); step("raw_stall", 0, 0, 1);
    ret(1, 5, 0); step("raw_wb", 0, 0, 1);
    step("raw_go", 1, 1, 0);
    chk("raw_pend5", pend(5), 0);
    chk("raw_pend6", pend(6), 1);
    // x0 is never a hazard; unused source fields are ignored
    dec(0, 0, 0, 0, 0, 1, 0); exp_q.push_back(0); step("x0_prod", 1, 1, 0);
    dec(0, 1, 0, 0, 0, 0, 0); exp_q.push_back(0); step("x0_cons", 1, 1, 0);
    dec(0, 0, 0, 0, 5, 1, 0); exp_q.push_back(5); step("w5", 1, 1, 0);
    dec(0, 0, 5, 0, 0, 0, 0); exp_q.push_back(0); step("use2_off", 1, 1, 0);
    dec(0, 0, 5, 1, 0, 0, 0); step("use2_on", 0, 0, 1);
    nodec();
    chk("x0_infl", 32'(dut.u_sb.infl_q), 5);
    ret(1, 6, 0); step("ret_a", 0, 0, 0);
    ret(1, 0, 0); step("ret_b", 0, 0, 0);
    ret(0, 0, 0); step("ret_c", 0, 0, 0);
    ret(1, 5, 0); step("ret_d", 0, 0, 0);
    ret(0, 0, 0); step("ret_e", 0, 0, 0);
    chk("drain_infl", 32'(dut.u_sb.infl_q), 0);
    chk("drain_pend5", pend(5), 0);
    // same-cycle issue and retire on x7 cancel out
    dec(0, 0, 0, 0, 7, 1, 0); exp_q.push_back(7); step("w7a", 1, 1, 0);
    exp_q.push_back(7); ret(1, 7, 0); step("w7b", 1, 1, 0);
    chk("x7_pend", pend(7), 1);
    chk("x7_infl", 32'(dut.u_sb.infl_q), 1);
    dec(7, 1, 0, 0, 8, 0, 0); exp_q.push_back(8); step("r7_stall", 0, 0, 1);
    ret(1, 7, 0); step("r7_wb", 0, 0, 1);
    step("r7_go", 1, 1, 0);
    nodec();
    ret(0, 0, 0); step("r7_ret", 0, 0, 0);
    chk("x7_pend_end", pend(7), 0);
    // a writer stalls once its rd counter is saturated
    for (int k = 0; k < 3; k++) begin
      dec(0, 0, 0, 0, 9, 1, 0); exp_q.push_back(9); step("w9", 1, 1, 0);
    end
    step("w9_max", 0, 0, 1);
    chk("w9_pend", pend(9), 3);
    nodec();
    for (int k = 0; k < 3; k++) begin
      ret(1, 9, 0); step("w9_ret", 0, 0, 0);
    end
    chk("w9_infl", 32'(dut.u_sb.infl_q), 0);
    // CSR serialisation
    dec(0, 0, 0, 0, 10, 1, 0); exp_q.push_back(10); step("add10", 1, 1, 0);
    dec(0, 0, 0, 0, 11, 1, 0); exp_q.push_back(11); step("add11", 1, 1, 0);
    dec(0, 0, 0, 0, 12, 1, 1); exp_q.push_back(12); step("csr_run", 0, 0, 1);
    chk("csr_drain", 32'(dut.state_q), 32'(DRAIN));
    ret(1, 10, 0); step("csr_r1", 0, 0, 1);
    ret(1, 11, 0); step("csr_r2", 0, 0, 1);
    step("csr_go", 1, 1, 0);
    chk("csr_serial", 32'(dut.state_q), 32'(SERIAL));
    dec(0, 0, 0, 0, 13, 1, 0); exp_q.push_back(13); step("ser_hold", 0, 0, 1);
    ret(1, 12, 1); step("ser_ret", 0, 0, 1);
    chk("ser_run", 32'(dut.state_q), 32'(RUN));
    step("young", 1, 1, 0);
    nodec();
    ret(1, 13, 0); step("young_ret", 0, 0, 0);
    chk("csr_infl", 32'(dut.u_sb.infl_q), 0);
    // redirect discards the decode slot, and cancels a DRAIN
    dec(0, 0, 0, 0, 14, 1, 0); exp_q.push_back(14); step("w14", 1, 1, 0);
    dec(14, 1, 0, 0, 15, 1, 0); redirect_i = 1; step("redir", 0, 1, 0);
    chk("redir_pend14", pend(14), 1);
    chk("redir_pend15", pend(15), 0);
    chk("redir_infl", 32'(dut.u_sb.infl_q), 1);
    dec(0, 0, 0, 0, 16, 1, 1); step("csr2", 0, 0, 1);
    chk("csr2_drain", 32'(dut.state_q), 32'(DRAIN));
    redirect_i = 1; step("redir2", 0, 1, 0);
    chk("redir2_run", 32'(dut.state_q), 32'(RUN));
    nodec();
    ret(1, 14, 0); step("fin", 0, 0, 0);
    chk("fin_infl", 32'(dut.u_sb.infl_q), 0);
    chk("fin_queue", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
